match_flow_controller: RTL

- Game-flow FSM directly downstream of the goal detector. Consumes its goal_scored / left_goal / game_over / p1_wins outputs.
- Sequences the match: title screen, kickoff countdown, live play, pause, post-goal freeze, game over.
- Drives play_enable to the ball/player physics, one-cycle ball/player reset pulses, and the game_restart pulse back into the goal detector.
- Also supplies banner/countdown status to the sprite/text renderer.

---
 rtl/match_flow_controller.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/match_flow_controller.sv
// Match sequencing FSM: title, kickoff countdown, live play, pause, post-goal freeze, game over.
// Drives physics enable, one-cycle reset pulses and renderer status from registered state only.
module match_flow_controller #(
   parameter int unsigned SECOND_FRAMES     = 60,
   parameter int unsigned COUNT_START       = 3,
   parameter int unsigned GOAL_PAUSE_FRAMES = 120
) (
   input  logic       frame_clk,
   input  logic       Reset_n,
   input  logic       start_key,
   input  logic       pause_key,
   input  logic       goal_scored,
   input  logic       left_goal,
   input  logic       game_over,
   input  logic       p1_wins,
   output logic       play_enable,
   output logic       ball_reset,
   output logic       players_reset,
   output logic       game_restart,
   output logic [2:0] state_code,
   output logic [1:0] countdown_digit,
   output logic       banner_goal,
   output logic       goal_side,
   output logic [1:0] banner_winner
);

   if (SECOND_FRAMES < 1 || SECOND_FRAMES > 255 ||
       COUNT_START < 1 || COUNT_START > 3 ||
       GOAL_PAUSE_FRAMES < 1 || GOAL_PAUSE_FRAMES > 255) begin : g_param_check
      $error("match_flow_controller: parameter out of range");
   end

   localparam logic [7:0] SecLast   = 8'(SECOND_FRAMES - 1);
   localparam logic [7:0] GoalLast  = 8'(GOAL_PAUSE_FRAMES - 1);
   localparam logic [1:0] DigitInit = 2'(COUNT_START);

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StCountdown = 3'd1,
      StPlay      = 3'd2,
      StPaused    = 3'd3,
      StGoalPause = 3'd4,
      StGameOver  = 3'd5
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] digit_q, digit_d;
   logic       side_q, side_d;
   logic       win_q, win_d;
   logic       start_q, pause_q;
   logic       ball_q, ball_d;
   logic       players_q, players_d;
   logic       restart_q, restart_d;
   logic       start_rise, pause_rise;

   assign start_rise = start_key & ~start_q;
   assign pause_rise = pause_key & ~pause_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      digit_d   = digit_q;
      side_d    = side_q;
      win_d     = win_q;
      ball_d    = 1'b0;
      players_d = 1'b0;
      restart_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_rise) begin
               state_d   = StCountdown;
               cnt_d     = 8'd0;
               digit_d   = DigitInit;
               restart_d = 1'b1;
               ball_d    = 1'b1;
               players_d = 1'b1;
            end
         end
         StCountdown: begin
            if (cnt_q == SecLast) begin
               cnt_d = 8'd0;
               if (digit_q == 2'd1) begin
                  state_d = StPlay;
                  digit_d = 2'd0;
               end else begin
                  digit_d = digit_q - 2'd1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StPlay: begin
            // A goal outranks a same-cycle pause so the score is never lost behind a pause.
            if (goal_scored) begin
               state_d = StGoalPause;
               side_d  = left_goal;
               cnt_d   = 8'd0;
            end else if (game_over) begin
               state_d = StGameOver;
               win_d   = p1_wins;
            end else if (pause_rise) begin
               state_d = StPaused;
            end
         end
         StPaused: begin
            if (pause_rise) begin
               state_d = StPlay;
            end
         end
         StGoalPause: begin
            if (cnt_q == GoalLast) begin
               cnt_d = 8'd0;
               if (game_over) begin
                  state_d = StGameOver;
                  win_d   = p1_wins;
               end else begin
                  state_d   = StCountdown;
                  digit_d   = DigitInit;
                  ball_d    = 1'b1;
                  players_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StGameOver: begin
            if (start_rise) begin
               state_d   = StCountdown;
               cnt_d     = 8'd0;
               digit_d   = DigitInit;
               side_d    = 1'b0;
               win_d     = 1'b0;
               restart_d = 1'b1;
               ball_d    = 1'b1;
               players_d = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 8'd0;
            digit_d = 2'd0;
         end
      endcase
   end

   always_ff @(posedge frame_clk) begin
      // Key history loads the live levels in reset so a held key cannot fire afterwards.
      start_q <= start_key;
      pause_q <= pause_key;
      if (!Reset_n) begin
         state_q   <= StIdle;
         cnt_q     <= 8'd0;
         digit_q   <= 2'd0;
         side_q    <= 1'b0;
         win_q     <= 1'b0;
         ball_q    <= 1'b0;
         players_q <= 1'b0;
         restart_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         digit_q   <= digit_d;
         side_q    <= side_d;
         win_q     <= win_d;
         ball_q    <= ball_d;
         players_q <= players_d;
         restart_q <= restart_d;
      end
   end

   assign state_code      = state_q;
   assign play_enable     = (state_q == StPlay);
   assign banner_goal     = (state_q == StGoalPause);
   assign countdown_digit = (state_q == StCountdown) ? digit_q : 2'd0;
   assign banner_winner   = (state_q != StGameOver) ? 2'd0 : (win_q ? 2'd1 : 2'd2);
   assign goal_side       = side_q;
   assign ball_reset      = ball_q;
   assign players_reset   = players_q;
   assign game_restart    = restart_q;

endmodule
